pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register, the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed control+data bundle of WIDTH bits between stages.
- Adds a valid/ready handshake for stall back-pressure and an optional skid entry so that in_ready is a pure flop output.
- Synchronous flush inserts a bubble; per-bit HOLD_MASK lets selected fields pass through a flush.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry
// (registered in_ready) and synchronous flush that lets HOLD_MASK bits pass through.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH        = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter logic [WIDTH-1:0] HOLD_MASK    = '0,
  parameter bit               SKID_EN      = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]       occ_q, occ_d;
  logic             push, pop;

  // With the skid entry, in_ready depends only on a flop, so it never
  // combinationally sees out_ready.
  generate
    if (SKID_EN) begin : g_skid_rdy
      assign in_ready = !skid_valid_q;
    end else begin : g_flow_rdy
      assign in_ready = !main_valid_q | out_ready;
    end
  endgenerate

  assign push = in_valid & in_ready;
  assign pop  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = (in_data & HOLD_MASK) | (BUBBLE_VALUE & ~HOLD_MASK);
      skid_data_d  = BUBBLE_VALUE;
    end else if (SKID_EN) begin
      if (skid_valid_q) begin
        // Full: in_ready is low, so only a pop can move state.
        if (pop) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end else if (main_valid_q) begin
        if (push && pop) begin
          main_data_d = in_data;
        end else if (push) begin
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
        end else if (pop) begin
          main_valid_d = 1'b0;
        end
      end else if (push) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end
    end else begin
      skid_valid_d = 1'b0;
      if (push) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end
    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= BUBBLE_VALUE;
      skid_data_q  <= BUBBLE_VALUE;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid and a no-skid instance share one random stimulus stream;
// each is checked against an ideal bounded FIFO model.
module tb_pipe_stage_reg;
  localparam logic [7:0] BUB  = 8'h00;
  localparam logic [7:0] HOLD = 8'h03;

  logic       CLK = 1'b0, RST = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0] a_out_data, b_out_data;
  logic [1:0] a_occ, b_occ;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(8), .BUBBLE_VALUE(BUB), .HOLD_MASK(HOLD), .SKID_EN(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .occupancy(a_occ));

  pipe_stage_reg #(.WIDTH(8), .BUBBLE_VALUE(BUB), .HOLD_MASK(HOLD), .SKID_EN(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .occupancy(b_occ));

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] la = BUB;
  logic [7:0] lb = BUB;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model view: a FIFO of capacity 2 (skid) or 1 (no skid); when empty the stage
  // shows the last value it emitted or the flush-masked bubble.
  task automatic mon(input string id, input bit skid, input logic ov, input logic [7:0] od,
                     input logic [1:0] occ, input logic ir, input int sz,
                     input logic [7:0] front, input logic [7:0] last);
    chk({id, "_out_valid"}, 8'(ov), 8'(sz != 0));
    chk({id, "_occupancy"}, 8'(occ), 8'(sz));
    chk({id, "_in_ready"}, 8'(ir), skid ? 8'(sz < 2) : 8'(sz == 0 || out_ready));
    chk({id, "_out_data"}, od, (sz != 0) ? front : last);
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST) begin
        qa.delete(); qb.delete();
        la = BUB; lb = BUB;
      end else begin
        mon("a", 1'b1, a_out_valid, a_out_data, a_occ, a_in_ready, qa.size(),
            (qa.size() != 0) ? qa[0] : BUB, la);
        mon("b", 1'b0, b_out_valid, b_out_data, b_occ, b_in_ready, qb.size(),
            (qb.size() != 0) ? qb[0] : BUB, lb);
        if (flush) begin
          qa.delete(); qb.delete();
          la = (in_data & HOLD) | (BUB & ~HOLD);
          lb = (in_data & HOLD) | (BUB & ~HOLD);
        end else begin
          if (out_ready && qa.size() != 0) la = qa.pop_front();
          if (out_ready && qb.size() != 0) lb = qb.pop_front();
        end
      end
    end
  end

  initial begin : recorder
    forever begin
      @(negedge CLK);
      #1;
      if (!RST && !flush && in_valid) begin
        if (a_in_ready) qa.push_back(in_data);
        if (b_in_ready) qb.push_back(in_data);
      end
    end
  end

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(posedge CLK);
    #1;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  task automatic chk_reset();
    chk("rst_a_out_valid", 8'(a_out_valid), 8'h00);
    chk("rst_a_out_data", a_out_data, BUB);
    chk("rst_a_occupancy", 8'(a_occ), 8'h00);
    chk("rst_a_in_ready", 8'(a_in_ready), 8'h01);
    chk("rst_b_out_valid", 8'(b_out_valid), 8'h00);
    chk("rst_b_out_data", b_out_data, BUB);
    chk("rst_b_in_ready", 8'(b_in_ready), 8'h01);
  endtask

  initial begin : stim
    #1 chk_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // streaming
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    chk("stream_a_first", a_out_data, 8'h11);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    chk("stream_a_second", a_out_data, 8'h22);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_a_third", a_out_data, 8'h33);
    chk("stream_a_occ", 8'(a_occ), 8'h01);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // stall into the skid entry, then drain in order
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    chk("stall_a_occ", 8'(a_occ), 8'h02);
    chk("stall_a_in_ready", 8'(a_in_ready), 8'h00);
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 8'hA3, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // flush with HOLD_MASK
    drive(1'b1, 8'h5C, 1'b0, 1'b0);
    drive(1'b1, 8'hFE, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_a_out_data", a_out_data, 8'h02);
    chk("flush_a_out_valid", 8'(a_out_valid), 8'h00);
    chk("flush_b_out_data", b_out_data, 8'h02);

    // flush while full
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flushfull_a_occ", 8'(a_occ), 8'h00);
    chk("flushfull_a_in_ready", 8'(a_in_ready), 8'h01);

    // no-skid combinational ready
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("noskid_b_stalled_ready", 8'(b_in_ready), 8'h00);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    #1 chk("noskid_b_comb_ready", 8'(b_in_ready), 8'h01);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("noskid_b_out_data", b_out_data, 8'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 24) == 0);
      if (i == 1500) begin
        drive(1'b1, 8'h9D, 1'b0, 1'b0);
        drive(1'b1, 8'h9E, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1 chk_reset();
        @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
      end
    end
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
